alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Initiator-side controller for the 8-bit combinational ALU.
- Accepts commands (opcode plus operand) over a valid/ready handshake and drives the ALU's inst/a/b inputs from registers.
- Captures the ALU's 9-bit result into an internal accumulator and carry flag, then returns the result over a valid/ready response channel.
- Executes the bit-clear and bit-set opcodes (13/14) locally, because the ALU leaves them unimplemented.

Parameters:
- RESET_ACC, 8'h00, accumulator value loaded on reset.
- TRAP_RESERVED, 1, when 1 opcode 4'b1111 flags rsp_err; when 0 it is treated as NOP.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  4  ALU opcode, same encoding as the ALU inst field.
- cmd_operand  input  8  operand; drives ALU b; bit index for ops 13/14.
- alu_inst  output  4  registered opcode to the ALU.
- alu_a  output  8  registered accumulator to ALU a.
- alu_b  output  8  registered operand to ALU b.
- alu_ans  input  9  ALU result; bit 8 is carry/borrow.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  8  accumulator after the command.
- rsp_carry  output  1  carry flag after the command.
- rsp_err  output  1  reserved opcode seen (only when TRAP_RESERVED=1).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.

Reset values:
- acc = RESET_ACC, carry = 0.
- State IDLE, cmd_ready = 1, rsp_valid = 0, rsp_err = 0.
- alu_inst = 4'b1000 (NOP), alu_a = RESET_ACC, alu_b = 0.

FSM states: IDLE, EXEC, RESP.

IDLE:
- cmd_ready = 1.
- On cmd_valid & cmd_ready: register cmd_op into alu_inst and cmd_operand into alu_b; alu_a tracks acc. Go to EXEC.

EXEC:
- cmd_ready = 0.
- ALU inputs are stable for this cycle; at the cycle's closing edge acc/carry are updated per the rules below. Go to RESP.

RESP:
- rsp_valid = 1; rsp_data/rsp_carry/rsp_err are held stable.
- On rsp_ready go to IDLE, and alu_inst returns to NOP.
- rsp_ready low holds the state indefinitely with outputs unchanged.

Latency and throughput:
- Command accepted at edge N; acc updated at edge N+1; rsp_valid high in cycle N+1 to N+2.
- One command in flight; a new command is accepted earliest the cycle after the response handshake.

Update rules (the ALU computes b-a for op 3, so SUB is operand − acc):
- Ops 2, 3, 5, 6: acc = alu_ans[7:0], carry = alu_ans[8]. Op 3's 9-bit wrap means bit 8 = borrow.
- Ops 0, 1, 4, 7, 10, 11, 12: acc = alu_ans[7:0], carry unchanged.
- Op 9: acc = 0, carry = 0.
- Op 8: acc and carry unchanged; alu_ans is not sampled, so the ALU's latching NOP is never relied on.
- Op 13: acc[cmd_operand[2:0]] = 0, computed locally; alu_ans ignored.
- Op 14: acc[cmd_operand[2:0]] = 1, computed locally.
- Op 15: acc and carry unchanged; rsp_err = TRAP_RESERVED.
- rsp_err clears when the next command is accepted.

Boundary conditions:
- Reset in any state aborts the command with no response and restores the reset values next cycle.
- cmd_valid while not in IDLE is ignored; the command must be held by the source.
- alu_a is the pre-update acc throughout EXEC.
- Accumulator wrap: 0xFF + 1 gives acc 0x00, carry 1. DEC of 0x00 gives acc 0xFF, carry 1 (borrow).

Optional Feature:
- Macro: ALU_SEQ_ZFLAG_EN.
- Defined: adds output port rsp_zero (1 bit), registered with acc, = (acc == 0) after each command. Reset value = (RESET_ACC == 0). Valid with rsp_valid.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then op 0 operand 0xF0 -> rsp_data 0xF0, rsp_carry 0; rsp_valid high exactly 2 cycles after accept.
- Then op 2 operand 0x20 -> rsp_data 0x10, rsp_carry 1. Then op 3 operand 0x05 -> 0x05 − 0x10 gives rsp_data 0xF5, rsp_carry 1.
- Op 9, then op 14 operand 0x03 -> 0x08; then op 13 operand 0x03 -> 0x00. Carry stays 0 and alu_ans is ignored on 13/14.
- Op 11 operand 0x3C -> 0xC3. Then op 8 -> 0xC3 held. Then op 15 -> rsp_err 1 and data 0xC3; the next command clears rsp_err.
- rsp_ready low for 3 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready 0, extra cmd_valid ignored; accept on release.
- Reset asserted during EXEC of op 2 -> no response; acc = RESET_ACC, carry 0, cmd_ready 1 next cycle. With ALU_SEQ_ZFLAG_EN defined, op 9 -> rsp_zero 1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: initiator-side controller for the 8-bit combinational ALU.
// Latency: command accepted at edge N, accumulator updated at edge N+1, response valid from N+1.
// Backpressure: one command in flight; cmd_ready low until rsp handshake, RESP holds while rsp_ready low.
//
// Ports:
//   clk, reset                  - clock and synchronous active-high reset
//   cmd_valid/ready/op/operand  - command channel (opcode uses ALU inst encoding)
//   alu_inst/alu_a/alu_b        - registered ALU inputs
//   alu_ans                     - ALU result, bit 8 = carry/borrow
//   rsp_valid/ready/data/carry/err - response channel
//   rsp_zero                    - only when macro ALU_SEQ_ZFLAG_EN is defined: acc == 0
module alu_sequencer #(
  parameter logic [7:0] RESET_ACC     = 8'h00,
  parameter bit         TRAP_RESERVED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [3:0] alu_inst,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [8:0] alu_ans,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic       rsp_zero
`endif
);

  localparam logic [3:0] OP_NOP = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;
  logic       accept;

  // FSM next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // Accumulator update, evaluated while the registered ALU inputs are stable in EXEC.
  // Clear, bit-clear and bit-set are done locally; NOP and reserved never sample alu_ans.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    err_d   = 1'b0;
    case (alu_inst)
      4'd2, 4'd3, 4'd5, 4'd6: begin
        acc_d   = alu_ans[7:0];
        carry_d = alu_ans[8];
      end
      4'd0, 4'd1, 4'd4, 4'd7, 4'd10, 4'd11, 4'd12: acc_d = alu_ans[7:0];
      4'd9: begin
        acc_d   = 8'h00;
        carry_d = 1'b0;
      end
      4'd13: acc_d[alu_b[2:0]] = 1'b0;
      4'd14: acc_d[alu_b[2:0]] = 1'b1;
      4'd15: err_d = TRAP_RESERVED;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= RESET_ACC;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      alu_inst <= OP_NOP;
      alu_a    <= RESET_ACC;
      alu_b    <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) begin
        acc_q   <= acc_d;
        carry_q <= carry_d;
        err_q   <= err_d;
      end
      if (accept) begin
        alu_inst <= cmd_op;
        alu_b    <= cmd_operand;
        err_q    <= 1'b0;
      end
      if (state_q == RESP && rsp_ready) alu_inst <= OP_NOP;
      // Frozen during EXEC so the ALU sees the pre-update accumulator.
      if (state_q != EXEC) alu_a <= acc_q;
    end
  end

  assign rsp_data  = acc_q;
  assign rsp_carry = carry_q;
  assign rsp_err   = err_q;

`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= (RESET_ACC == 8'h00);
    end else if (state_q == EXEC) begin
      zero_q <= (acc_d == 8'h00);
    end
  end
  assign rsp_zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer with a behavioural ALU.
// Latency: n/a (testbench).
// Backpressure: exercises rsp_ready stalls and ignored cmd_valid while busy.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_operand;
  logic [3:0] alu_inst;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [8:0] alu_ans;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
`ifdef ALU_SEQ_ZFLAG_EN
  logic       rsp_zero;
`endif

  alu_sequencer #(.RESET_ACC(8'h00), .TRAP_RESERVED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err)
`ifdef ALU_SEQ_ZFLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unimplemented/NOP opcodes return junk so ignoring them is visible.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:  return {1'b0, b};
      4'd1:  return {1'b0, a & b};
      4'd2:  return {1'b0, a} + {1'b0, b};
      4'd3:  return {1'b0, b} - {1'b0, a};
      4'd4:  return {1'b0, a | b};
      4'd5:  return {1'b0, a} + 9'd1;
      4'd6:  return {1'b0, a} - 9'd1;
      4'd7:  return {1'b0, a ^ b};
      4'd9:  return 9'h000;
      4'd10: return {a, 1'b0};
      4'd11: return {1'b0, ~b};
      4'd12: return {1'b0, a >> 1};
      default: return 9'h1A5;
    endcase
  endfunction

  always_comb alu_ans = alu_fn(alu_inst, alu_a, alu_b);

  typedef struct packed {
    logic [7:0] data;
    logic       carry;
    logic       err;
    logic       zero;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_acc;
  logic       ref_carry;
  logic       ref_err;
  int         n_cmp;
  int         n_fail;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sequencer: applies the update rules to the bench's own accumulator copy.
  task automatic model_cmd(input logic [3:0] op, input logic [7:0] opnd);
    logic [8:0] ans;
    exp_t e;
    ans = alu_fn(op, ref_acc, opnd);
    ref_err = 1'b0;
    case (op)
      4'd2, 4'd3, 4'd5, 4'd6: {ref_carry, ref_acc} = ans;
      4'd0, 4'd1, 4'd4, 4'd7, 4'd10, 4'd11, 4'd12: ref_acc = ans[7:0];
      4'd9: begin ref_acc = 8'h00; ref_carry = 1'b0; end
      4'd13: ref_acc[opnd[2:0]] = 1'b0;
      4'd14: ref_acc[opnd[2:0]] = 1'b1;
      4'd15: ref_err = 1'b1;
      default: ;
    endcase
    e.data = ref_acc; e.carry = ref_carry; e.err = ref_err; e.zero = (ref_acc == 8'h00);
    sb_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [7:0] opnd, input int stall);
    int   cnt;
    exp_t e;
    logic [7:0] pre_acc;
    cmd_valid = 1'b1; cmd_op = op; cmd_operand = opnd;
    cnt = 0;
    while (cmd_ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    if (cnt >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout op=%0d: cmd_ready=%b, required 1", op, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    pre_acc = ref_acc;
    tick();                       // accept edge
    cmd_valid = 1'b0;
    model_cmd(op, opnd);
    // EXEC cycle
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL exec_rsp_valid op=%0d: got %b, required 0", op, rsp_valid); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL exec_cmd_ready op=%0d: got %b, required 0", op, cmd_ready); end
    n_cmp++; if (alu_inst !== op) begin n_fail++; $display("FAIL exec_alu_inst: got %0d, required %0d", alu_inst, op); end
    n_cmp++; if (alu_a !== pre_acc) begin n_fail++; $display("FAIL exec_alu_a op=%0d: got %h, required %h", op, alu_a, pre_acc); end
    n_cmp++; if (alu_b !== opnd) begin n_fail++; $display("FAIL exec_alu_b op=%0d: got %h, required %h", op, alu_b, opnd); end
    tick();
    // RESP: first cycle and any stall cycles
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rsp_latency op=%0d: rsp_valid %b, required 1", op, rsp_valid); end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++; $display("FAIL scoreboard_empty op=%0d: got 0 entries, required 1", op);
      return;
    end
    e = sb_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        // Spurious command while busy must be ignored.
        cmd_valid = 1'b1; cmd_op = 4'd5; cmd_operand = 8'h77;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid cyc=%0d: got %b, required 1", s, rsp_valid); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_cmd_ready cyc=%0d: got %b, required 0", s, cmd_ready); end
      end
      n_cmp++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL rsp_data op=%0d cyc=%0d: got %h, required %h", op, s, rsp_data, e.data); end
      n_cmp++; if (rsp_carry !== e.carry) begin n_fail++; $display("FAIL rsp_carry op=%0d cyc=%0d: got %b, required %b", op, s, rsp_carry, e.carry); end
      n_cmp++; if (rsp_err !== e.err) begin n_fail++; $display("FAIL rsp_err op=%0d cyc=%0d: got %b, required %b", op, s, rsp_err, e.err); end
`ifdef ALU_SEQ_ZFLAG_EN
      n_cmp++; if (rsp_zero !== e.zero) begin n_fail++; $display("FAIL rsp_zero op=%0d: got %b, required %b", op, rsp_zero, e.zero); end
`endif
      if (s < stall) tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_drop op=%0d: rsp_valid %b, required 0", op, rsp_valid); end
    n_cmp++; if (alu_inst !== 4'd8) begin n_fail++; $display("FAIL inst_nop op=%0d: alu_inst %0d, required 8", op, alu_inst); end
  endtask

  task automatic check_reset_state(input string tag);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_cmd_ready: got %b, required 1", tag, cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_valid: got %b, required 0", tag, rsp_valid); end
    n_cmp++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL %s_rsp_err: got %b, required 0", tag, rsp_err); end
    n_cmp++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL %s_acc: got %h, required 00", tag, rsp_data); end
    n_cmp++; if (rsp_carry !== 1'b0) begin n_fail++; $display("FAIL %s_carry: got %b, required 0", tag, rsp_carry); end
    n_cmp++; if (alu_inst !== 4'd8) begin n_fail++; $display("FAIL %s_alu_inst: got %0d, required 8", tag, alu_inst); end
    n_cmp++; if (alu_a !== 8'h00) begin n_fail++; $display("FAIL %s_alu_a: got %h, required 00", tag, alu_a); end
    n_cmp++; if (alu_b !== 8'h00) begin n_fail++; $display("FAIL %s_alu_b: got %h, required 00", tag, alu_b); end
`ifdef ALU_SEQ_ZFLAG_EN
    n_cmp++; if (rsp_zero !== 1'b1) begin n_fail++; $display("FAIL %s_zero: got %b, required 1", tag, rsp_zero); end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_operand = 8'h00; rsp_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    ref_acc = 8'h00; ref_carry = 1'b0; ref_err = 1'b0;
    check_reset_state("reset");
  endtask

  task automatic test_arith();
    send_cmd(4'd0, 8'hF0, 0);   // load -> F0, c0
    send_cmd(4'd2, 8'h20, 0);   // F0+20 -> 10, c1
    send_cmd(4'd3, 8'h05, 0);   // 05-10 -> F5, borrow
  endtask

  task automatic test_bitops();
    send_cmd(4'd9,  8'h00, 0);  // clear
    send_cmd(4'd14, 8'h03, 0);  // set bit 3 -> 08
    send_cmd(4'd13, 8'h03, 0);  // clear bit 3 -> 00
    send_cmd(4'd14, 8'hFF, 0);  // index uses low 3 bits -> 80
    send_cmd(4'd13, 8'hF7, 0);  // -> 00
  endtask

  task automatic test_logic_err();
    send_cmd(4'd11, 8'h3C, 0);  // -> C3
    send_cmd(4'd8,  8'h55, 0);  // NOP holds C3
    send_cmd(4'd15, 8'h00, 0);  // reserved -> err
    send_cmd(4'd5,  8'h00, 0);  // INC -> C4, err cleared
    send_cmd(4'd7,  8'hFF, 0);  // XOR -> 3B
    send_cmd(4'd12, 8'h00, 0);  // SHR -> 1D
    send_cmd(4'd10, 8'h00, 0);  // SHL -> 3A
  endtask

  task automatic test_wrap();
    send_cmd(4'd0, 8'hFF, 0);
    send_cmd(4'd5, 8'h00, 0);   // FF+1 -> 00, c1
    send_cmd(4'd9, 8'h00, 0);
    send_cmd(4'd6, 8'h00, 0);   // 00-1 -> FF, borrow
  endtask

  task automatic test_back_to_back();
    send_cmd(4'd1, 8'h5A, 3);   // stall 3 cycles, spurious cmd ignored
    send_cmd(4'd4, 8'h81, 0);   // OR -> DB
  endtask

  task automatic test_reset_exec();
    int cnt;
    cmd_valid = 1'b1; cmd_op = 4'd2; cmd_operand = 8'h33;
    cnt = 0;
    while (cmd_ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tick();                      // accept
    cmd_valid = 1'b0;
    reset = 1'b1;
    tick();                      // reset edge during EXEC
    reset = 1'b0;
    ref_acc = 8'h00; ref_carry = 1'b0; ref_err = 1'b0;
    check_reset_state("rst_exec");
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_exec_no_rsp: got %b, required 0", rsp_valid); end
  endtask

  task automatic test_zero();
    send_cmd(4'd0, 8'h42, 0);
    send_cmd(4'd9, 8'h00, 0);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_arith();
    test_bitops();
    test_logic_err();
    test_wrap();
    test_back_to_back();
    test_reset_exec();
    test_zero();
    n_cmp++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries, required 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
